// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MdOp encodings, default latencies and datapath width for the E-stage MDU
package mdu_pkg;

    localparam int MD_W            = 32;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_MADD  = 3'd7
    } md_op_e;

endpackage

// File: rtl/mdu_busy_counter.sv
// rtl/mdu_busy_counter.sv - loadable 4-bit down-counter giving busy and a done pulse on the 1->0 step
module mdu_busy_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       busy,
    output logic       done
);

    logic [3:0] count_q, count_d;
    logic       busy_q, busy_d;

    // Load starts an operation; otherwise count down while busy and drop busy on the final step
    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (load) begin
            count_d = load_val;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            count_d = count_q - 4'd1;
            busy_d  = (count_q != 4'd1);
        end
    end

    // Counter and busy registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    // High during the cycle whose closing edge takes the counter from 1 to 0
    assign done = busy_q && (count_q == 4'd1);

endmodule

// File: rtl/mdu_stage_e.sv
// rtl/mdu_stage_e.sv - E-stage multiply/divide unit with HI/LO; MDU_MADD_EN adds signed multiply-accumulate
module mdu_stage_e
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic [2:0]      MdOp,
    input  logic [MD_W-1:0] SrcA_E,
    input  logic [MD_W-1:0] SrcB_E,
    output logic [MD_W-1:0] HI,
    output logic [MD_W-1:0] LO,
    output logic            Busy,
    output logic            MdBusy
);

    logic [MD_W-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            start_edge, is_mult, is_div, cnt_load, done, busy_w;
    logic [3:0]      cnt_load_val;

    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]        prod_u;
    logic [MD_W-1:0]    a_mag, b_mag, b_safe, uq, ur, sq, sr, bu_safe, uq_u, ur_u;
    logic               a_neg, b_neg, div0;

    assign start_edge = Start && !Busy;

    // Decode which ops run on the multi-cycle counter; MADD decodes only when compiled in
    always_comb begin
        is_mult = (MdOp == MD_MULT) || (MdOp == MD_MULTU);
`ifdef MDU_MADD_EN
        if (MdOp == MD_MADD) is_mult = 1'b1;
`endif
        is_div  = (MdOp == MD_DIV) || (MdOp == MD_DIVU);
    end

    assign cnt_load     = start_edge && (is_mult || is_div);
    assign cnt_load_val = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

    mdu_busy_counter u_busy_counter (
        .clk      (CLK),
        .reset    (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .busy     (busy_w),
        .done     (done)
    );

    // Arithmetic on latched operands only, so the pipeline may change the source ports mid-op
    always_comb begin
        sa64    = {{32{a_q[31]}}, a_q};
        sb64    = {{32{b_q[31]}}, b_q};
        prod_s  = sa64 * sb64;
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        a_neg   = a_q[31];
        b_neg   = b_q[31];
        a_mag   = a_neg ? (32'd0 - a_q) : a_q;
        b_mag   = b_neg ? (32'd0 - b_q) : b_q;
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq      = a_mag / b_safe;
        ur      = a_mag % b_safe;
        // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
        sq      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        sr      = a_neg ? (32'd0 - ur) : ur;
        bu_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        uq_u    = a_q / bu_safe;
        ur_u    = a_q % bu_safe;
        div0    = (b_q == 32'd0);
    end

    // Next-state for operand latches and HI/LO: mthi/mtlo at the start edge, results at done
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (cnt_load) begin
            a_d  = SrcA_E;
            b_d  = SrcB_E;
            op_d = MdOp;
        end
        if (start_edge && MdOp == MD_MTHI) hi_d = SrcA_E;
        if (start_edge && MdOp == MD_MTLO) lo_d = SrcA_E;
        if (done) begin
            case (op_q)
                MD_MULT:  {hi_d, lo_d} = prod_s;
                MD_MULTU: {hi_d, lo_d} = prod_u;
                MD_DIV:   if (!div0) begin hi_d = sr;   lo_d = sq;   end
                MD_DIVU:  if (!div0) begin hi_d = ur_u; lo_d = uq_u; end
`ifdef MDU_MADD_EN
                MD_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
                default: ;
            endcase
        end
    end

    // Architectural HI/LO and latched operation state
    always_ff @(posedge CLK) begin
        if (Reset) begin
            hi_q <= '0;
            lo_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MD_NONE;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    assign HI     = hi_q;
    assign LO     = lo_q;
    assign Busy   = busy_w;
    assign MdBusy = Start | busy_w;

endmodule

// File: tb/tb_mdu_stage_e.sv
// tb/tb_mdu_stage_e.sv - directed self-checking bench for mdu_stage_e
module tb_mdu_stage_e;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MdOp = 3'd0;
    logic [31:0] SrcA_E = 32'd0;
    logic [31:0] SrcB_E = 32'd0;
    logic [31:0] HI, LO;
    logic        Busy, MdBusy;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_stage_e dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Start  (Start),
        .MdOp   (MdOp),
        .SrcA_E (SrcA_E),
        .SrcB_E (SrcB_E),
        .HI     (HI),
        .LO     (LO),
        .Busy   (Busy),
        .MdBusy (MdBusy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        assert (!(Start && Busy)) else $error("Start asserted while Busy");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] val);
        Start = 1'b1; MdOp = op; SrcA_E = val;
        step();
        Start = 1'b0; MdOp = 3'd0;
        if (op == 3'd5) m_hi = val; else m_lo = val;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit garbage);
        int cyc;
        Start = 1'b1; MdOp = op; SrcA_E = a; SrcB_E = b;
        #1;
        check({tag, "_mdbusy_start"}, 64'(MdBusy), 64'd1);
        step();
        Start = 1'b0; MdOp = 3'd0;
        cyc = 0;
        while (Busy && cyc < 20) begin
            check({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
            if (garbage) begin
                SrcA_E = $urandom;
                SrcB_E = $urandom;
            end
            step();
            cyc++;
        end
        check({tag, "_cycles"}, 64'(cyc), 64'(n));
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        step(); step();
        Reset = 1'b0;
        #1;
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_mdbusy", 64'(MdBusy), 64'd0);

        do_op("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        do_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b1);
        do_op("mult_negneg", 3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 5, 32'h0, 32'h6, 1'b1);
        do_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        check("mt_pre_hi", 64'(HI), 64'h11);
        check("mt_pre_lo", 64'(LO), 64'h22);
        do_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, 1'b0);
        do_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b1);
        do_op("divu", 3'd4, 32'hFFFFFFFF, 32'h10, 10, 32'hF, 32'h0FFFFFFF, 1'b0);

        // back-to-back mthi/mtlo
        Start = 1'b1; MdOp = 3'd5; SrcA_E = 32'hAAAA5555;
        #1;
        check("mthi_mdbusy", 64'(MdBusy), 64'd1);
        step();
        check("mthi_hi", 64'(HI), 64'hAAAA5555);
        check("mthi_busy", 64'(Busy), 64'd0);
        MdOp = 3'd6; SrcA_E = 32'h12345678;
        #1;
        check("mtlo_mdbusy", 64'(MdBusy), 64'd1);
        step();
        Start = 1'b0; MdOp = 3'd0;
        #1;
        check("mtlo_lo", 64'(LO), 64'h12345678);
        check("mtlo_hi", 64'(HI), 64'hAAAA5555);
        check("mtlo_busy", 64'(Busy), 64'd0);
        check("mtlo_mdbusy_after", 64'(MdBusy), 64'd0);
        m_hi = 32'hAAAA5555; m_lo = 32'h12345678;

        // reset in the middle of a divide
        Start = 1'b1; MdOp = 3'd3; SrcA_E = 32'd100; SrcB_E = 32'd3;
        step();
        Start = 1'b0; MdOp = 3'd0;
        step(); step(); step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        check("rstmid_hi", 64'(HI), 64'd0);
        check("rstmid_lo", 64'(LO), 64'd0);
        check("rstmid_busy", 64'(Busy), 64'd0);
        repeat (12) step();
        check("rstmid_late", {HI, LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        do_op("mult_after_rst", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0);

        // MD_NONE start has no effect
        Start = 1'b1; MdOp = 3'd0; SrcA_E = 32'hDEADBEEF;
        step();
        Start = 1'b0;
        check("none_busy", 64'(Busy), 64'd0);
        check("none_hilo", {HI, LO}, {m_hi, m_lo});

`ifdef MDU_MADD_EN
        mt(3'd6, 32'd10);
        mt(3'd5, 32'd0);
        do_op("madd", 3'd7, 32'd3, 32'd4, 5, 32'd0, 32'd22, 1'b1);
        mt(3'd5, 32'd0);
        mt(3'd6, 32'd0);
        do_op("madd_neg", 3'd7, 32'hFFFFFFFF, 32'd1, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`else
        Start = 1'b1; MdOp = 3'd7; SrcA_E = 32'd3; SrcB_E = 32'd4;
        step();
        Start = 1'b0; MdOp = 3'd0;
        check("op7_busy", 64'(Busy), 64'd0);
        repeat (6) step();
        check("op7_hilo", {HI, LO}, {m_hi, m_lo});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
